// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display path.
package clock_pkg;

  // Segment vector a..g, bit 0 = a, active-low.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  localparam int NUM_DIGITS = 6;

  // Slots whose decimal point forms the HH:MM:SS colons.
  localparam logic [5:0] COLON_SLOTS = 6'b010100;

  // Index of the last digit slot (hours tens).
  localparam logic [2:0] LAST_SLOT = 3'd5;

  // One-hot anode pattern for a digit slot (slot must be < NUM_DIGITS).
  function automatic logic [5:0] slot_anode(input logic [2:0] slot);
    slot_anode = 6'b000001 << slot;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Nibbles 10..15 are not valid BCD and show a dash.
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  // Standard digit shapes, dash for anything out of BCD range.
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_seg_scanner.sv
// Six-digit multiplexed seven-segment driver with blinking colon and
// 8-level PWM brightness. Digits are shown from a frame register that is
// reloaded only at the frame boundary, so a frame never tears.
// Optional build macro LEADING_ZERO_BLANK_EN: blank the hours-tens digit
// when it is zero (anode timing unchanged).
module clock_seg_scanner
  import clock_pkg::*;
#(
  parameter int unsigned SCAN_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [23:0] bcd_digits,
  input  logic        half_sec,
  input  logic [2:0]  brightness,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [5:0]  dig_an
);

  logic [SCAN_LOG2-1:0] cnt;
  logic [2:0]           slot;
  logic [23:0]          frame;
  logic                 colon_on;

  logic [3:0] nibble;
  seg7_t      seg_dec;
  logic       cnt_wrap;
  logic       frame_end;
  logic       pwm_on;
  logic       dead_time;
  logic       lz_blank;

  assign cnt_wrap  = &cnt;
  assign frame_end = cnt_wrap && (slot == LAST_SLOT);
  assign pwm_on    = (cnt[SCAN_LOG2-1 -: 3] <= brightness);
  assign dead_time = (cnt == '0);

  // Select the nibble for the slot being scanned from the frame register.
  always_comb begin
    nibble = 4'd0;
    case (slot)
      3'd0:    nibble = frame[3:0];
      3'd1:    nibble = frame[7:4];
      3'd2:    nibble = frame[11:8];
      3'd3:    nibble = frame[15:12];
      3'd4:    nibble = frame[19:16];
      3'd5:    nibble = frame[23:20];
      default: nibble = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = (slot == LAST_SLOT) && (nibble == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  // Scan state, frame snapshot, colon toggle and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      slot     <= '0;
      frame    <= '0;
      colon_on <= 1'b1;
      seg_n    <= SEG_BLANK;
      dp_n     <= 1'b1;
      dig_an   <= '0;
    end else if (ena) begin
      cnt <= cnt + 1'b1;
      if (cnt_wrap) begin
        slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
      end
      if (frame_end) begin
        frame <= bcd_digits;
      end
      if (half_sec) begin
        colon_on <= ~colon_on;
      end
      seg_n  <= lz_blank ? SEG_BLANK : seg_dec;
      dp_n   <= ~(colon_on && COLON_SLOTS[slot]);
      dig_an <= (pwm_on && !dead_time) ? slot_anode(slot) : 6'b000000;
    end else begin
      // Disabled: hold the scan position, blank everything.
      seg_n  <= SEG_BLANK;
      dp_n   <= 1'b1;
      dig_an <= '0;
    end
  end

endmodule

// File: tb/tb_clock_seg_scanner.sv
// Directed bench for clock_seg_scanner with SCAN_LOG2 = 4.
// Valid/ready does not apply here: inputs are level-sampled each clock.
module tb_clock_seg_scanner;

  localparam int SL = 4;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [23:0] bcd_digits;
  logic        half_sec;
  logic [2:0]  brightness;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  dig_an;

  int checks = 0;
  int errors = 0;

  // Bench-side scan position: state the DUT had before the last edge.
  logic [3:0] m_cnt;
  logic [2:0] m_slot;
  logic [3:0] out_cnt;
  logic [2:0] out_slot;

  clock_seg_scanner #(.SCAN_LOG2(SL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bcd_digits (bcd_digits),
    .half_sec   (half_sec),
    .brightness (brightness),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_an     (dig_an)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs then reflect the pre-edge scan position.
  task automatic tick();
    @(posedge clk);
    #1;
    out_cnt  = m_cnt;
    out_slot = m_slot;
    if (ena) begin
      m_cnt = m_cnt + 4'd1;
      if (m_cnt == 4'd0) m_slot = (m_slot == 3'd5) ? 3'd0 : m_slot + 3'd1;
    end
  endtask

  // Tick until outputs correspond to the given slot/cnt, bounded.
  task automatic run_to(input logic [2:0] s, input logic [3:0] c);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (out_slot == s && out_cnt == c) found = 1'b1;
    end
    check("run_to_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic count_slot2_anode(input string tag, input int exp_hi);
    int hi;
    int bad;
    hi = 0;
    bad = 0;
    run_to(3'd1, 4'd15);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (dig_an == 6'b000100) hi++;
      else if (dig_an != 6'b000000) bad++;
    end
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_bad"}, bad, 0);
  endtask

  task automatic count_colon_frame(input string tag, input int exp_low);
    int low;
    int bad;
    low = 0;
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      tick();
      if (dp_n == 1'b0) begin
        low++;
        if (out_slot != 3'd2 && out_slot != 3'd4) bad++;
      end
    end
    check({tag, "_low"}, low, exp_low);
    check({tag, "_bad"}, bad, 0);
  endtask

  initial begin
    int n_an;
    int n_seg;
    int n_dp;
    rst_n      = 1'b0;
    ena        = 1'b1;
    half_sec   = 1'b0;
    brightness = 3'd7;
    bcd_digits = 24'h123456;
    m_cnt      = '0;
    m_slot     = '0;
    out_cnt    = '0;
    out_slot   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", {25'd0, seg_n}, 32'h7F);
    check("rst_an", {26'd0, dig_an}, 32'h0);
    check("rst_dp", {31'd0, dp_n}, 32'h1);
    rst_n = 1'b1;

    // First frame after reset shows zeros; dead time then anode.
    tick();
    check("f0_seg_s0", {25'd0, seg_n}, 32'b1000000);
    check("f0_dead", {26'd0, dig_an}, 32'h0);
    check("f0_dp_s0", {31'd0, dp_n}, 32'h1);
    tick();
    check("f0_an_s0", {26'd0, dig_an}, 32'b000001);
    run_to(3'd3, 4'd5);
    check("f0_seg_s3", {25'd0, seg_n}, 32'b1000000);

    // Snapshot of 123456 at frame end; mid-frame change must not tear.
    run_to(3'd5, 4'd15);
    run_to(3'd0, 4'd2);
    check("snap_s0_6", {25'd0, seg_n}, 32'b0000010);
    run_to(3'd2, 4'd3);
    check("snap_s2_4", {25'd0, seg_n}, 32'b0011001);
    check("colon_s2", {31'd0, dp_n}, 32'h0);
    bcd_digits = 24'h000000;
    run_to(3'd5, 4'd3);
    check("snap_s5_1", {25'd0, seg_n}, 32'b1111001);
    run_to(3'd0, 4'd3);
    check("next_s0_0", {25'd0, seg_n}, 32'b1000000);

    // PWM duty per slot
    brightness = 3'd0;
    count_slot2_anode("pwm0", 1);
    brightness = 3'd7;
    count_slot2_anode("pwm7", 15);
    brightness = 3'd3;
    count_slot2_anode("pwm3", 7);
    brightness = 3'd7;

    // Colon blink: off after first pulse, back on after second
    half_sec = 1'b1;
    tick();
    half_sec = 1'b0;
    count_colon_frame("colon_off", 0);
    half_sec = 1'b1;
    tick();
    half_sec = 1'b0;
    count_colon_frame("colon_on", 32);

    // Invalid nibble in slot 1 shows a dash
    bcd_digits = 24'h1234A6;
    run_to(3'd5, 4'd15);
    run_to(3'd1, 4'd4);
    check("dash_s1", {25'd0, seg_n}, 32'b0111111);

    // Hours-tens zero: blank only with the leading-zero option
    bcd_digits = 24'h012345;
    run_to(3'd5, 4'd15);
    run_to(3'd0, 4'd4);
    check("lz_s0_5", {25'd0, seg_n}, 32'b0010010);
    run_to(3'd5, 4'd4);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_s5", {25'd0, seg_n}, 32'h7F);
`else
    check("lz_s5", {25'd0, seg_n}, 32'b1000000);
`endif
    check("lz_s5_an", {26'd0, dig_an}, 32'b100000);

    // Disable for 50 cycles with an ignored half_sec pulse
    run_to(3'd3, 4'd6);
    ena = 1'b0;
    n_an = 0;
    n_seg = 0;
    n_dp = 0;
    for (int i = 0; i < 50; i++) begin
      half_sec = (i == 20);
      tick();
      if (dig_an != 6'b000000) n_an++;
      if (seg_n != 7'h7F) n_seg++;
      if (dp_n != 1'b1) n_dp++;
    end
    half_sec = 1'b0;
    check("dis_an", n_an, 0);
    check("dis_seg", n_seg, 0);
    check("dis_dp", n_dp, 0);
    ena = 1'b1;
    tick();
    check("resume_an", {26'd0, dig_an}, 32'b001000);
    check("resume_seg", {25'd0, seg_n}, 32'b0100100);
    run_to(3'd4, 4'd2);
    check("resume_colon", {31'd0, dp_n}, 32'h0);

    // Asynchronous reset mid-scan
    run_to(3'd4, 4'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_seg", {25'd0, seg_n}, 32'h7F);
    check("mid_rst_an", {26'd0, dig_an}, 32'h0);
    check("mid_rst_dp", {31'd0, dp_n}, 32'h1);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_cnt  = '0;
    m_slot = '0;
    tick();
    check("post_rst_seg", {25'd0, seg_n}, 32'b1000000);
    check("post_rst_dead", {26'd0, dig_an}, 32'h0);
    tick();
    check("post_rst_an", {26'd0, dig_an}, 32'b000001);
    run_to(3'd2, 4'd1);
    check("post_rst_colon", {31'd0, dp_n}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
